// File: rtl/barrel_spawner_pkg.sv
// barrel_spawner_pkg: shared Kong game codes, screen geometry and barrel defaults
package barrel_spawner_pkg;
   typedef enum logic {KONG_INITIAL = 1'b0, KONG_PLAYING = 1'b1} kong_state_e;
   typedef enum logic [1:0] {
      KONG_NORMAL = 2'b00,
      KONG_GET    = 2'b01,
      KONG_HOLD   = 2'b10,
      KONG_DROP   = 2'b11
   } kong_anim_e;
   typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int XW = 10;
   localparam int YW = 9;
endpackage

// File: rtl/barrel_spawner_slot.sv
// barrel_slot: one barrel's live flag, position and roll direction with spawn, clear, move and retire
module barrel_slot
   import barrel_spawner_pkg::*;
#(
   parameter int SPAWN_X  = 182,
   parameter int SPAWN_Y  = 166,
   parameter int X_MIN    = 16,
   parameter int X_MAX    = 608,
   parameter int STEP     = 2,
   parameter int ROW_DROP = 40,
   parameter int Y_FLOOR  = 440
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic          tick,
   output logic          active,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y
);
   logic          active_q, active_d;
   logic [XW-1:0] x_q, x_d, mx;
   logic [YW-1:0] y_q, y_d;
   dir_e          dir_q, dir_d;
   logic [XW:0]   xr;
   logic [YW:0]   ny;
   logic          right, hit, move, retire;
   always_comb begin
      right    = dir_q == DIR_RIGHT;
      xr       = {1'b0, x_q} + (XW+1)'(STEP);
      hit      = right ? xr > (XW+1)'(X_MAX) : {1'b0, x_q} < (XW+1)'(X_MIN + STEP);
      mx       = hit ? (right ? XW'(X_MAX) : XW'(X_MIN)) : (right ? xr[XW-1:0] : x_q - XW'(STEP));
      ny       = {1'b0, y_q} + (hit ? (YW+1)'(ROW_DROP) : '0);
      retire   = ny >= (YW+1)'(Y_FLOOR);
      move     = tick & active_q & ~clear;
      active_d = clear ? 1'b0 : load ? 1'b1 : move ? ~retire : active_q;
      x_d      = clear ? x_q : load ? XW'(SPAWN_X) : (move & ~retire) ? mx : x_q;
      y_d      = clear ? y_q : load ? YW'(SPAWN_Y) : (move & ~retire) ? ny[YW-1:0] : y_q;
      dir_d    = clear ? dir_q : load ? DIR_RIGHT : (move & hit) ? (right ? DIR_LEFT : DIR_RIGHT) : dir_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         x_q      <= XW'(SPAWN_X);
         y_q      <= YW'(SPAWN_Y);
         dir_q    <= DIR_RIGHT;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_q    <= dir_d;
      end
   end
   assign active = active_q;
   assign x      = x_q;
   assign y      = y_q;
endmodule

// File: rtl/barrel_spawner.sv
// barrel_spawner: launches a barrel on each new Kong DROP pose and rolls the barrel pool every tick
module barrel_spawner
   import barrel_spawner_pkg::*;
#(
   parameter int NUM_BARRELS = 4,
   parameter int SPAWN_X     = 182,
   parameter int SPAWN_Y     = 166,
   parameter int X_MIN       = 16,
   parameter int X_MAX       = 608,
   parameter int STEP        = 2,
   parameter int ROW_DROP    = 40,
   parameter int Y_FLOOR     = 440,
   localparam int SW         = NUM_BARRELS > 1 ? $clog2(NUM_BARRELS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   kong_state,
   input  logic [1:0]             kong_anim,
   input  logic                   over,
   input  logic                   tick,
   input  logic [SW-1:0]          sel,
   output logic [XW-1:0]          barrel_x,
   output logic [YW-1:0]          barrel_y,
   output logic                   barrel_valid,
   output logic [NUM_BARRELS-1:0] active,
   output logic                   spawn_pulse,
   output logic                   spawn_miss,
   output logic [7:0]             spawn_count
);
   logic [1:0]             anim_q, anim_d;
   logic                   spawn_pulse_q, spawn_pulse_d;
   logic                   spawn_miss_q, spawn_miss_d;
   logic [7:0]             count_q, count_d;
   logic                   clearing, drop_edge, spawn;
   logic [NUM_BARRELS-1:0] free_oh, load;
   logic [XW-1:0]          xs [NUM_BARRELS];
   logic [YW-1:0]          ys [NUM_BARRELS];
   always_comb begin
      clearing      = kong_state == KONG_INITIAL || over;
      drop_edge     = kong_anim == KONG_DROP && anim_q != KONG_DROP && !clearing;
      free_oh       = ~active & (active + NUM_BARRELS'(1));
      spawn         = drop_edge & |free_oh;
      load          = spawn ? free_oh : '0;
      anim_d        = kong_anim;
      spawn_pulse_d = spawn;
      spawn_miss_d  = drop_edge & ~|free_oh;
      count_d       = count_q + 8'(spawn);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         anim_q        <= KONG_NORMAL;
         spawn_pulse_q <= 1'b0;
         spawn_miss_q  <= 1'b0;
         count_q       <= '0;
      end else begin
         anim_q        <= anim_d;
         spawn_pulse_q <= spawn_pulse_d;
         spawn_miss_q  <= spawn_miss_d;
         count_q       <= count_d;
      end
   end
   for (genvar g = 0; g < NUM_BARRELS; g++) begin : g_slot
      barrel_slot #(
         .SPAWN_X (SPAWN_X),
         .SPAWN_Y (SPAWN_Y),
         .X_MIN   (X_MIN),
         .X_MAX   (X_MAX),
         .STEP    (STEP),
         .ROW_DROP(ROW_DROP),
         .Y_FLOOR (Y_FLOOR)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .clear (clearing),
         .load  (load[g]),
         .tick  (tick),
         .active(active[g]),
         .x     (xs[g]),
         .y     (ys[g])
      );
   end
   always_comb begin
      barrel_valid = 1'b0;
      barrel_x     = '0;
      barrel_y     = '0;
      for (int i = 0; i < NUM_BARRELS; i++) begin
         if (int'(sel) == i) begin
            barrel_valid = active[i];
            barrel_x     = xs[i];
            barrel_y     = ys[i];
         end
      end
   end
   assign spawn_pulse = spawn_pulse_q;
   assign spawn_miss  = spawn_miss_q;
   assign spawn_count = count_q;
endmodule

// File: tb/tb_barrel_spawner.sv
// tb_barrel_spawner: directed scenario checks of spawning, rolling, retiring and clearing
module tb_barrel_spawner;
   logic       clk = 1'b0;
   logic       rst, kong_state, over, tick;
   logic [1:0] kong_anim, sel;
   logic [9:0] barrel_x;
   logic [8:0] barrel_y;
   logic       barrel_valid, spawn_pulse, spawn_miss;
   logic [3:0] active;
   logic [7:0] spawn_count;
   int         checks = 0;
   int         errors = 0;

   barrel_spawner dut (
      .clk         (clk),
      .rst         (rst),
      .kong_state  (kong_state),
      .kong_anim   (kong_anim),
      .over        (over),
      .tick        (tick),
      .sel         (sel),
      .barrel_x    (barrel_x),
      .barrel_y    (barrel_y),
      .barrel_valid(barrel_valid),
      .active      (active),
      .spawn_pulse (spawn_pulse),
      .spawn_miss  (spawn_miss),
      .spawn_count (spawn_count)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drop();
      kong_anim = 2'b11;
      cyc(1);
      kong_anim = 2'b00;
      cyc(1);
   endtask

   task automatic test_reset();
      rst = 1'b1; kong_state = 1'b0; kong_anim = 2'b00; over = 1'b0; tick = 1'b0; sel = 2'd0;
      cyc(2);
      checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", active); end
      checks++; if (spawn_pulse !== 1'b0 || spawn_miss !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", spawn_pulse, spawn_miss); end
      checks++; if (spawn_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", spawn_count); end
      checks++; if (barrel_x !== 10'd182 || barrel_y !== 9'd166 || barrel_valid !== 1'b0) begin errors++; $display("FAIL reset_slot0: got (%0d,%0d,%b) expected (182,166,0)", barrel_x, barrel_y, barrel_valid); end
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic test_first_spawn();
      kong_state = 1'b1;
      cyc(1);
      kong_anim = 2'b11;
      cyc(1);
      checks++; if (active !== 4'b0001) begin errors++; $display("FAIL spawn1_active: got %b expected 0001", active); end
      checks++; if (spawn_pulse !== 1'b1) begin errors++; $display("FAIL spawn1_pulse: got %b expected 1", spawn_pulse); end
      checks++; if (spawn_count !== 8'd1) begin errors++; $display("FAIL spawn1_count: got %0d expected 1", spawn_count); end
      checks++; if (barrel_x !== 10'd182 || barrel_y !== 9'd166 || barrel_valid !== 1'b1) begin errors++; $display("FAIL spawn1_slot0: got (%0d,%0d,%b) expected (182,166,1)", barrel_x, barrel_y, barrel_valid); end
      cyc(1);
      checks++; if (spawn_pulse !== 1'b0) begin errors++; $display("FAIL spawn1_pulse_width: got %b expected 0", spawn_pulse); end
   endtask

   task automatic test_held_drop();
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (spawn_pulse) pulses++;
      end
      checks++; if (pulses !== 0 || spawn_count !== 8'd1) begin errors++; $display("FAIL held_drop: got %0d extra pulses count %0d expected 0 count 1", pulses, spawn_count); end
      kong_anim = 2'b00;
      cyc(1);
      kong_anim = 2'b11;
      sel = 2'd1;
      cyc(1);
      checks++; if (active !== 4'b0011 || spawn_count !== 8'd2 || spawn_pulse !== 1'b1) begin errors++; $display("FAIL spawn2: got active %b count %0d pulse %b expected 0011 2 1", active, spawn_count, spawn_pulse); end
      checks++; if (barrel_x !== 10'd182 || barrel_valid !== 1'b1) begin errors++; $display("FAIL spawn2_slot1: got (%0d,%b) expected (182,1)", barrel_x, barrel_valid); end
      kong_anim = 2'b00;
      cyc(1);
   endtask

   task automatic test_pool_full();
      drop();
      drop();
      checks++; if (active !== 4'b1111 || spawn_count !== 8'd4) begin errors++; $display("FAIL fill: got active %b count %0d expected 1111 4", active, spawn_count); end
      kong_anim = 2'b11;
      cyc(1);
      checks++; if (spawn_miss !== 1'b1 || spawn_pulse !== 1'b0) begin errors++; $display("FAIL miss: got miss %b pulse %b expected 1 0", spawn_miss, spawn_pulse); end
      checks++; if (active !== 4'b1111 || spawn_count !== 8'd4) begin errors++; $display("FAIL miss_state: got active %b count %0d expected 1111 4", active, spawn_count); end
      kong_anim = 2'b00;
      cyc(1);
      checks++; if (spawn_miss !== 1'b0) begin errors++; $display("FAIL miss_width: got %b expected 0", spawn_miss); end
   endtask

   task automatic test_clear();
      over = 1'b1;
      cyc(1);
      checks++; if (active !== 4'b0000 || spawn_count !== 8'd4) begin errors++; $display("FAIL over_clear: got active %b count %0d expected 0000 4", active, spawn_count); end
      kong_anim = 2'b11;
      cyc(1);
      checks++; if (active !== 4'b0000 || spawn_pulse !== 1'b0 || spawn_miss !== 1'b0) begin errors++; $display("FAIL over_drop: got active %b pulse %b miss %b expected 0000 0 0", active, spawn_pulse, spawn_miss); end
      over = 1'b0;
      cyc(1);
      checks++; if (active !== 4'b0000 || spawn_pulse !== 1'b0) begin errors++; $display("FAIL held_after_over: got active %b pulse %b expected 0000 0", active, spawn_pulse); end
      kong_state = 1'b0;
      kong_anim = 2'b00;
      cyc(1);
      kong_anim = 2'b11;
      cyc(1);
      checks++; if (active !== 4'b0000 || spawn_count !== 8'd4 || spawn_miss !== 1'b0) begin errors++; $display("FAIL initial_blocks: got active %b count %0d miss %b expected 0000 4 0", active, spawn_count, spawn_miss); end
      kong_anim = 2'b00;
   endtask

   task automatic test_roll();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      kong_state = 1'b1;
      sel = 2'd0;
      kong_anim = 2'b11;
      cyc(1);
      kong_anim = 2'b00;
      tick = 1'b1;
      cyc(212);
      checks++; if (barrel_x !== 10'd606 || barrel_y !== 9'd166) begin errors++; $display("FAIL roll_606: got (%0d,%0d) expected (606,166)", barrel_x, barrel_y); end
      cyc(1);
      checks++; if (barrel_x !== 10'd608 || barrel_y !== 9'd166) begin errors++; $display("FAIL roll_608: got (%0d,%0d) expected (608,166)", barrel_x, barrel_y); end
      cyc(1);
      checks++; if (barrel_x !== 10'd608 || barrel_y !== 9'd206) begin errors++; $display("FAIL right_bounce: got (%0d,%0d) expected (608,206)", barrel_x, barrel_y); end
      cyc(1);
      checks++; if (barrel_x !== 10'd606 || barrel_y !== 9'd206) begin errors++; $display("FAIL roll_left: got (%0d,%0d) expected (606,206)", barrel_x, barrel_y); end
      cyc(295);
      checks++; if (barrel_x !== 10'd16 || barrel_y !== 9'd206) begin errors++; $display("FAIL roll_16: got (%0d,%0d) expected (16,206)", barrel_x, barrel_y); end
      cyc(1);
      checks++; if (barrel_x !== 10'd16 || barrel_y !== 9'd246) begin errors++; $display("FAIL left_bounce: got (%0d,%0d) expected (16,246)", barrel_x, barrel_y); end
      cyc(1);
      checks++; if (barrel_x !== 10'd18) begin errors++; $display("FAIL roll_right: got %0d expected 18", barrel_x); end
      cyc(1483);
      checks++; if (barrel_x !== 10'd608 || barrel_y !== 9'd406 || barrel_valid !== 1'b1) begin errors++; $display("FAIL pre_retire: got (%0d,%0d,%b) expected (608,406,1)", barrel_x, barrel_y, barrel_valid); end
      tick = 1'b0;
   endtask

   task automatic test_retire_miss();
      drop();
      drop();
      drop();
      checks++; if (active !== 4'b1111 || spawn_count !== 8'd4) begin errors++; $display("FAIL refill: got active %b count %0d expected 1111 4", active, spawn_count); end
      kong_anim = 2'b11;
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      kong_anim = 2'b00;
      checks++; if (spawn_miss !== 1'b1 || spawn_pulse !== 1'b0) begin errors++; $display("FAIL retire_miss: got miss %b pulse %b expected 1 0", spawn_miss, spawn_pulse); end
      checks++; if (active !== 4'b1110) begin errors++; $display("FAIL retire_active: got %b expected 1110", active); end
      sel = 2'd1;
      #1;
      checks++; if (barrel_x !== 10'd184) begin errors++; $display("FAIL slot1_moved: got %0d expected 184", barrel_x); end
      cyc(1);
      kong_anim = 2'b11;
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      kong_anim = 2'b00;
      checks++; if (active !== 4'b1111 || spawn_count !== 8'd5 || spawn_pulse !== 1'b1) begin errors++; $display("FAIL respawn: got active %b count %0d pulse %b expected 1111 5 1", active, spawn_count, spawn_pulse); end
      checks++; if (barrel_x !== 10'd186) begin errors++; $display("FAIL slot1_tick: got %0d expected 186", barrel_x); end
      sel = 2'd0;
      #1;
      checks++; if (barrel_x !== 10'd182 || barrel_y !== 9'd166 || barrel_valid !== 1'b1) begin errors++; $display("FAIL new_no_move: got (%0d,%0d,%b) expected (182,166,1)", barrel_x, barrel_y, barrel_valid); end
   endtask

   task automatic test_reset_mid_roll();
      tick = 1'b1;
      cyc(5);
      rst = 1'b1;
      sel = 2'd1;
      cyc(1);
      tick = 1'b0;
      checks++; if (active !== 4'b0000 || spawn_count !== 8'd0 || spawn_pulse !== 1'b0 || spawn_miss !== 1'b0) begin errors++; $display("FAIL midroll_reset: got active %b count %0d pulse %b miss %b expected 0000 0 0 0", active, spawn_count, spawn_pulse, spawn_miss); end
      checks++; if (barrel_x !== 10'd182 || barrel_y !== 9'd166) begin errors++; $display("FAIL midroll_pos: got (%0d,%0d) expected (182,166)", barrel_x, barrel_y); end
      rst = 1'b0;
      cyc(1);
   endtask

   initial begin
      test_reset();
      test_first_spawn();
      test_held_drop();
      test_pool_full();
      test_clear();
      test_roll();
      test_retire_miss();
      test_reset_mid_roll();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
